// File: rtl/vrf_output_router.sv
// VRF output router: steers a commanded burst of VRF read beats to the DMA
// write-back port, the compute port, or discards it.
module vrf_output_router #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_dest,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] dma_data,
  output logic                  dma_valid,
  input  logic                  dma_ready,
  output logic [DATA_WIDTH-1:0] comp_data,
  output logic                  comp_valid,
  input  logic                  comp_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUTE = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  state_e                  state_q, state_d;
  logic [1:0]              dest_q, dest_d;
  logic [LEN_WIDTH-1:0]    remaining_q, remaining_d;
  logic                    init_q;
  logic                    dma_valid_q, dma_valid_d;
  logic [DATA_WIDTH-1:0]   dma_data_q, dma_data_d;
  logic                    comp_valid_q, comp_valid_d;
  logic [DATA_WIDTH-1:0]   comp_data_q, comp_data_d;

  logic cmd_ready_s;
  logic in_ready_s;
  logic load_dma_s;
  logic load_comp_s;
  logic dma_drain_s;
  logic comp_drain_s;

  assign dma_drain_s  = dma_valid_q && dma_ready;
  assign comp_drain_s = comp_valid_q && comp_ready;

  // Holds cmd_ready low until the first clock edge after reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
    end
  end

  // State, command and output-stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      dest_q       <= 2'b00;
      remaining_q  <= LEN_ZERO;
      dma_valid_q  <= 1'b0;
      dma_data_q   <= DATA_ZERO;
      comp_valid_q <= 1'b0;
      comp_data_q  <= DATA_ZERO;
    end else begin
      state_q      <= state_d;
      dest_q       <= dest_d;
      remaining_q  <= remaining_d;
      dma_valid_q  <= dma_valid_d;
      dma_data_q   <= dma_data_d;
      comp_valid_q <= comp_valid_d;
      comp_data_q  <= comp_data_d;
    end
  end

  // Next-state, handshake and load decisions.
  always_comb begin
    state_d     = state_q;
    dest_d      = dest_q;
    remaining_d = remaining_q;
    cmd_ready_s = 1'b0;
    in_ready_s  = 1'b0;
    load_dma_s  = 1'b0;
    load_comp_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready_s = init_q;
        if (cmd_valid && init_q) begin
          dest_d      = cmd_dest;
          remaining_d = cmd_len;
          // A zero-length burst still takes the FLUSH slot, keeping the
          // accept -> FLUSH -> DONE -> IDLE spacing uniform.
          state_d     = (cmd_len != LEN_ZERO) ? S_ROUTE : S_FLUSH;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ROUTE: begin
        case (dest_q)
          2'b00:   in_ready_s = 1'b1;
          2'b01:   in_ready_s = !dma_valid_q || dma_ready;
          default: in_ready_s = !comp_valid_q || comp_ready;
        endcase
        if (in_valid && in_ready_s) begin
          load_dma_s  = (dest_q == 2'b01);
          load_comp_s = dest_q[1];
          if (remaining_q != LEN_ZERO) begin
            remaining_d = remaining_q - LEN_ONE;
          end else begin
            remaining_d = LEN_ZERO;
          end
          if (remaining_q <= LEN_ONE) begin
            state_d = S_FLUSH;
          end else begin
            state_d = S_ROUTE;
          end
        end else begin
          state_d = S_ROUTE;
        end
      end

      S_FLUSH: begin
        case (dest_q)
          2'b00:   state_d = S_DONE;
          2'b01:   state_d = (!dma_valid_q || dma_ready) ? S_DONE : S_FLUSH;
          default: state_d = (!comp_valid_q || comp_ready) ? S_DONE : S_FLUSH;
        endcase
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // One-entry output stages: a load wins over a same-cycle drain.
  always_comb begin
    dma_data_d  = dma_data_q;
    comp_data_d = comp_data_q;
    if (load_dma_s) begin
      dma_valid_d = 1'b1;
      dma_data_d  = in_data;
    end else if (dma_drain_s) begin
      dma_valid_d = 1'b0;
    end else begin
      dma_valid_d = dma_valid_q;
    end
    if (load_comp_s) begin
      comp_valid_d = 1'b1;
      comp_data_d  = in_data;
    end else if (comp_drain_s) begin
      comp_valid_d = 1'b0;
    end else begin
      comp_valid_d = comp_valid_q;
    end
  end

  assign cmd_ready  = cmd_ready_s;
  assign in_ready   = in_ready_s;
  assign dma_valid  = dma_valid_q;
  assign dma_data   = dma_data_q;
  assign comp_valid = comp_valid_q;
  assign comp_data  = comp_data_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_vrf_output_router.sv
// Directed bench for vrf_output_router: cycle-by-cycle vectors with
// hand-computed expectations plus negedge handshake counters.
module tb_vrf_output_router;

  localparam int DW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_dest;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dma_data;
  logic          dma_valid;
  logic          dma_ready;
  logic [DW-1:0] comp_data;
  logic          comp_valid;
  logic          comp_ready;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int in_hs    = 0;
  int dma_hs   = 0;
  int comp_hs  = 0;
  int cmd_hs   = 0;
  int dma_vcnt = 0;
  int comp_vcnt = 0;
  int base_done, base_in, base_dma, base_comp, base_cmd, base_dv, base_cv;

  vrf_output_router #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dest   (cmd_dest),
    .cmd_len    (cmd_len),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dma_data   (dma_data),
    .dma_valid  (dma_valid),
    .dma_ready  (dma_ready),
    .comp_data  (comp_data),
    .comp_valid (comp_valid),
    .comp_ready (comp_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Mid-cycle event counters.
  always @(negedge clk) begin
    if (done)                    done_cnt  <= done_cnt + 1;
    if (in_valid && in_ready)    in_hs     <= in_hs + 1;
    if (dma_valid && dma_ready)  dma_hs    <= dma_hs + 1;
    if (comp_valid && comp_ready) comp_hs  <= comp_hs + 1;
    if (cmd_valid && cmd_ready)  cmd_hs    <= cmd_hs + 1;
    if (dma_valid)               dma_vcnt  <= dma_vcnt + 1;
    if (comp_valid)              comp_vcnt <= comp_vcnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    base_done = done_cnt; base_in = in_hs; base_dma = dma_hs; base_comp = comp_hs;
    base_cmd = cmd_hs; base_dv = dma_vcnt; base_cv = comp_vcnt;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_dest = 2'b00; cmd_len = 8'd0;
    in_data = 16'h0000; in_valid = 1'b0; dma_ready = 1'b0; comp_ready = 1'b0;

    // Reset state
    #3;
    check_eq("rst_ctrl", {26'd0, cmd_ready, in_ready, dma_valid, comp_valid, busy, done}, 32'd0);
    check_eq("rst_dma_data", {16'd0, dma_data}, 32'd0);
    check_eq("rst_comp_data", {16'd0, comp_data}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check_eq("cmd_ready_before_edge", {31'd0, cmd_ready}, 32'd0);
    tick();
    check_eq("cmd_ready_after_rst", {31'd0, cmd_ready}, 32'd1);
    check_eq("in_ready_idle", {31'd0, in_ready}, 32'd0);
    check_eq("busy_idle", {31'd0, busy}, 32'd0);

    // DMA burst, len 4, no backpressure
    snap();
    cmd_valid = 1'b1; cmd_dest = 2'b01; cmd_len = 8'd4; dma_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h0011 + 16'(i);
      #1;
      check_eq("dma_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      check_eq("dma_valid", {31'd0, dma_valid}, 32'd1);
      check_eq("dma_data", {16'd0, dma_data}, 32'h0011 + 32'(i));
      check_eq("dma_comp_valid", {31'd0, comp_valid}, 32'd0);
    end
    in_valid = 1'b0;
    check_eq("dma_flush_busy_done", {30'd0, busy, done}, 32'd2);
    tick();
    check_eq("dma_done", {30'd0, done, dma_valid}, 32'd2);
    tick();
    check_eq("dma_idle", {29'd0, done, busy, cmd_ready}, 32'd1);
    check_eq("dma_done_count", 32'(done_cnt - base_done), 32'd1);
    check_eq("dma_hs_count", 32'(dma_hs - base_dma), 32'd4);
    check_eq("dma_comp_vcnt", 32'(comp_vcnt - base_cv), 32'd0);

    // Compute burst with backpressure
    snap();
    cmd_valid = 1'b1; cmd_dest = 2'b10; cmd_len = 8'd3; comp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    in_valid = 1'b1; in_data = 16'hA001; comp_ready = 1'b0;
    #1;
    check_eq("comp_in_ready_empty", {31'd0, in_ready}, 32'd1);
    tick();
    check_eq("comp_first", {15'd0, comp_valid, comp_data}, 32'h1A001);
    in_data = 16'hA002;
    #1;
    check_eq("comp_in_ready_full1", {31'd0, in_ready}, 32'd0);
    tick();
    check_eq("comp_hold1", {15'd0, comp_valid, comp_data}, 32'h1A001);
    check_eq("comp_in_ready_full2", {31'd0, in_ready}, 32'd0);
    tick();
    check_eq("comp_hold2", {15'd0, comp_valid, comp_data}, 32'h1A001);
    comp_ready = 1'b1;
    #1;
    check_eq("comp_in_ready_drain", {31'd0, in_ready}, 32'd1);
    tick();
    check_eq("comp_second", {15'd0, comp_valid, comp_data}, 32'h1A002);
    in_data = 16'hA003;
    tick();
    check_eq("comp_third", {15'd0, comp_valid, comp_data}, 32'h1A003);
    in_valid = 1'b0;
    check_eq("comp_flush_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("comp_flush_done", {31'd0, done}, 32'd0);
    tick();
    check_eq("comp_done", {30'd0, done, comp_valid}, 32'd2);
    tick();
    check_eq("comp_hs_count", 32'(comp_hs - base_comp), 32'd3);
    check_eq("comp_in_count", 32'(in_hs - base_in), 32'd3);
    check_eq("comp_dma_vcnt", 32'(dma_vcnt - base_dv), 32'd0);
    check_eq("comp_done_count", 32'(done_cnt - base_done), 32'd1);

    // Discard burst, len 5
    snap();
    cmd_valid = 1'b1; cmd_dest = 2'b00; cmd_len = 8'd5;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h5500 + 16'(i);
      #1;
      check_eq("disc_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
    end
    check_eq("disc_flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check_eq("disc_done", {31'd0, done}, 32'd1);
    tick();
    check_eq("disc_in_count", 32'(in_hs - base_in), 32'd5);
    check_eq("disc_no_valid", 32'((dma_vcnt - base_dv) + (comp_vcnt - base_cv)), 32'd0);
    check_eq("disc_done_count", 32'(done_cnt - base_done), 32'd1);

    // Zero-length command, in_valid held high
    snap();
    cmd_valid = 1'b1; cmd_dest = 2'b01; cmd_len = 8'd0;
    tick();
    cmd_valid = 1'b0;
    check_eq("zero_flush", {29'd0, busy, done, in_ready}, 32'd4);
    tick();
    check_eq("zero_done", {31'd0, done}, 32'd1);
    tick();
    check_eq("zero_idle", {30'd0, cmd_ready, done}, 32'd2);
    in_valid = 1'b0;
    check_eq("zero_in_count", 32'(in_hs - base_in), 32'd0);

    // Reset mid-burst
    snap();
    cmd_valid = 1'b1; cmd_dest = 2'b01; cmd_len = 8'd8; dma_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h0800 + 16'(i);
      tick();
    end
    in_valid = 1'b0; dma_ready = 1'b0;
    #1;
    check_eq("mid_pre_rst", {15'd0, dma_valid, dma_data}, 32'h10802);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ctrl", {28'd0, dma_valid, busy, done, cmd_ready}, 32'd0);
    check_eq("mid_rst_data", {16'd0, dma_data}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check_eq("mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("mid_no_done", 32'(done_cnt - base_done), 32'd0);
    snap();
    cmd_valid = 1'b1; cmd_dest = 2'b01; cmd_len = 8'd2; dma_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    in_valid = 1'b1; in_data = 16'h0B01;
    tick();
    check_eq("mid_new_b1", {15'd0, dma_valid, dma_data}, 32'h10B01);
    in_data = 16'h0B02;
    tick();
    check_eq("mid_new_b2", {15'd0, dma_valid, dma_data}, 32'h10B02);
    in_valid = 1'b0;
    tick();
    check_eq("mid_new_done", {31'd0, done}, 32'd1);
    tick();
    check_eq("mid_new_hs", 32'(dma_hs - base_dma), 32'd2);

    // Command held valid during a busy burst
    snap();
    cmd_valid = 1'b1; cmd_dest = 2'b01; cmd_len = 8'd4; dma_ready = 1'b1;
    tick();
    cmd_dest = 2'b10; cmd_len = 8'd1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h0D00 + 16'(i);
      #1;
      check_eq("busy_cmd_ready_route", {31'd0, cmd_ready}, 32'd0);
      tick();
    end
    in_valid = 1'b0;
    check_eq("busy_cmd_ready_flush", {31'd0, cmd_ready}, 32'd0);
    tick();
    check_eq("busy_cmd_ready_done", {30'd0, cmd_ready, done}, 32'd1);
    tick();
    check_eq("busy_cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    check_eq("busy_cmd_hs1", 32'(cmd_hs - base_cmd), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check_eq("busy_cmd_hs2", 32'(cmd_hs - base_cmd), 32'd2);
    check_eq("busy_second_busy", {31'd0, busy}, 32'd1);
    in_valid = 1'b1; in_data = 16'hC0DE; comp_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("busy_second_comp", {15'd0, comp_valid, comp_data}, 32'h1C0DE);
    check_eq("busy_second_dma_idle", {31'd0, dma_valid}, 32'd0);
    tick();
    check_eq("busy_second_done", {31'd0, done}, 32'd1);
    tick();
    check_eq("busy_done_count", 32'(done_cnt - base_done), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
